pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (if_id, id_ex, ex_mem, mem_wb). Each cycle it decides per-stage enable/flush from cache hits, load-use hazards, EX-stage redirects and halt. On halt it sequences the dcache writeback before asserting halt. Sits beside the datapath and drives each pipeline register's en/flush pair and the PC enable.

Parameters:
REG_AW, 5, register-address width of rs/rt/rd fields
CNT_W, 32, width of performance counters (used only with STALL_CTR_EN)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  icache returned instruction this cycle
dhit  in  1  dcache completed MEM-stage access this cycle
mem_dreq  in  1  MEM-stage instruction is a load/store
id_rs, id_rt  in  REG_AW  source registers of ID instruction
ex_rd  in  REG_AW  destination register of EX instruction
ex_memread  in  1  EX instruction is a load
ex_redirect  in  1  branch taken / jump resolved in EX (PC mux selects target)
wb_halt  in  1  halt instruction valid in WB
dflush_done  in  1  dcache finished writeback/flush
pc_en  out  1  PC load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  pipeline register clears (consumer gives flush priority over en)
dflush_req  out  1  request dcache writeback
halt  out  1  system halted
state  out  2  FSM state (BOOT=0, RUN=1, DFLUSH=2, HALTED=3)

Behaviour:
- FSM register reset asynchronously to BOOT; outputs are combinational from state + inputs.
- BOOT (exactly 1 cycle after nRST rises): all en=0, all four flush=1, pc_en=0, halt=0, dflush_req=0; -> RUN.
- RUN, per-cycle priority (first match wins):
  1. wb_halt: all en=0, all flush=0, pc_en=0; -> DFLUSH.
  2. dmem stall (mem_dreq & ~dhit): all en=0, pc_en=0, flush=0 (whole pipe frozen).
  3. ex_redirect: pc_en=1 regardless of ihit; if_id_flush=1, id_ex_flush=1; ex_mem_en=mem_wb_en=1.
  4. load-use (ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt)): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  5. ~ihit: pc_en=0, if_id_flush=1 (bubble), id_ex_en=ex_mem_en=mem_wb_en=1.
  6. else: pc_en=1, all en=1, flush=0.
- Unlisted outputs are 0 in each case; flush and en are never both 1 for one register.
- mem_dreq & dhit in the same cycle is not a stall; case 3-6 evaluation proceeds.
- Load-use with ~ihit: load-use wins, so IF/ID holds its valid instruction.
- DFLUSH: all en/pc_en=0, dflush_req=1 until dflush_done seen; same cycle dflush_done=1 -> HALTED.
- HALTED: all en=0, dflush_req=0, halt=1; sticky until nRST.
- nRST low mid-operation: immediate return to BOOT, halt drops.

Optional Feature:
STALL_CTR_EN: adds outputs cyc_cnt, dstall_cnt, lu_stall_cnt, istall_cnt, redirect_cnt (CNT_W each, async reset 0). In RUN each cycle cyc_cnt+1 and exactly one of the others +1 per matching case 2/4/5/3. Counters wrap modulo 2^CNT_W and freeze outside RUN. Without the macro the ports and logic are absent.

Test Plan:
- Reset release, ihit=1: cycle 0 state=BOOT with all flush=1, en=0; cycle 1 state=RUN, all en=1, pc_en=1.
- mem_dreq=1, dhit=0 for 3 cycles then dhit=1: all en=0 for 3 cycles, then all en=1 with no flush.
- ex_memread=1, ex_rd=8, id_rt=8: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Repeat with ex_rd=0: no stall.
- ex_redirect=1 with ihit=0 and a load-use match: pc_en=1, if_id_flush=1, id_ex_flush=1 (redirect beats load-use/istall).
- ihit=0 alone: pc_en=0, if_id_flush=1, other en=1.
- wb_halt=1 -> DFLUSH with dflush_req=1. dflush_done after 4 cycles -> HALTED, halt=1, stays through further wb_halt toggles until nRST.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: per-stage enable/flush, PC enable and halt/dcache-flush sequencing.
// Optional performance counters are built in when STALL_CTR_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dreq,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic              wb_halt,
  input  logic              dflush_done,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              dflush_req,
  output logic              halt,
  output logic [1:0]        state
`ifdef STALL_CTR_EN
  ,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  dstall_cnt,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  istall_cnt,
  output logic [CNT_W-1:0]  redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DFLUSH = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   load_use_s;
  logic   dstall_s;
  logic   lu_s;
  logic   istall_s;
  logic   redir_s;

  // A load to r0 never creates a dependency, so it cannot stall.
  assign load_use_s = ex_memread && (ex_rd != {REG_AW{1'b0}}) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

  assign state = state_r;

  // Sequencer state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-stage enable/flush decode; RUN causes are prioritised top-down.
  always_comb begin
    state_next_s = state_r;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    dflush_req   = 1'b0;
    halt         = 1'b0;
    dstall_s     = 1'b0;
    lu_s         = 1'b0;
    istall_s     = 1'b0;
    redir_s      = 1'b0;
    case (state_r)
      BOOT: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        state_next_s = RUN;
      end
      RUN: begin
        if (wb_halt) begin
          state_next_s = DFLUSH;
        end else if (mem_dreq && !dhit) begin
          dstall_s = 1'b1;
        end else if (ex_redirect) begin
          redir_s     = 1'b1;
          pc_en       = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end else if (load_use_s) begin
          // IF/ID holds its instruction; a bubble goes into ID/EX.
          lu_s        = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end else if (!ihit) begin
          istall_s    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
        end
      end
      DFLUSH: begin
        dflush_req = 1'b1;
        if (dflush_done) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = DFLUSH;
        end
      end
      HALTED: begin
        halt         = 1'b1;
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = BOOT;
      end
    endcase
  end

`ifdef STALL_CTR_EN
  // Performance counters advance only while running; each RUN cycle bumps at most one cause.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt      <= {CNT_W{1'b0}};
      dstall_cnt   <= {CNT_W{1'b0}};
      lu_stall_cnt <= {CNT_W{1'b0}};
      istall_cnt   <= {CNT_W{1'b0}};
      redirect_cnt <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (dstall_s) dstall_cnt <= dstall_cnt + CNT_W'(1);
      if (lu_s) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      if (istall_s) istall_cnt <= istall_cnt + CNT_W'(1);
      if (redir_s) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_s;
  assign unused_s = &{1'b0, dstall_s, lu_s, istall_s, redir_s};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b0, dhit = 1'b0, mem_dreq = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rd = 5'd0;
  logic       ex_memread = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0, dflush_done = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       dflush_req, halt;
  logic [1:0] state;
`ifdef STALL_CTR_EN
  logic [31:0] cyc_cnt, dstall_cnt, lu_stall_cnt, istall_cnt, redirect_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt), .dflush_done(dflush_done),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .dflush_req(dflush_req), .halt(halt), .state(state)
`ifdef STALL_CTR_EN
    , .cyc_cnt(cyc_cnt), .dstall_cnt(dstall_cnt), .lu_stall_cnt(lu_stall_cnt),
    .istall_cnt(istall_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // {state, halt, dflush_req, pc_en, en[if_id,id_ex,ex_mem,mem_wb], flush[if_id,id_ex,ex_mem,mem_wb]}
  function automatic logic [12:0] mk(input logic [1:0] st, input logic h, input logic dr,
                                     input logic pc, input logic [3:0] en, input logic [3:0] fl);
    return {st, h, dr, pc, en, fl};
  endfunction

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  logic [12:0] boot_o, run_go, frozen, redir, lu, istall, dfl, hlt;

  task automatic cyc(input string nm, input logic [12:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic clr;
    ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    ex_memread = 1'b0; ex_redirect = 1'b0; wb_halt = 1'b0; dflush_done = 1'b0;
  endtask

  // Monitor: compares the combinational outputs against the oldest pending expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [12:0] act, e;
      string nm;
      act = {state, halt, dflush_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %b want %b", nm, act, e);
    end
  end

  initial begin
    boot_o = mk(2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    run_go = mk(2'd1, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000);
    frozen = mk(2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    redir  = mk(2'd1, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b1100);
    lu     = mk(2'd1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0100);
    istall = mk(2'd1, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1000);
    dfl    = mk(2'd2, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    hlt    = mk(2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);

    @(posedge CLK); #1;
    cyc("in_reset", boot_o);
    clr(); nRST = 1'b1;
    cyc("boot_cycle", boot_o);
    cyc("first_run", run_go);

    mem_dreq = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) cyc("dstall", frozen);
    dhit = 1'b1;
    cyc("dhit_release", run_go);

    clr(); ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
    cyc("load_use_rt", lu);
    ex_rd = 5'd0; id_rt = 5'd0;
    cyc("load_r0_nostall", run_go);
    ex_rd = 5'd5; id_rs = 5'd5; ihit = 1'b0;
    cyc("lu_beats_istall", lu);
    ex_redirect = 1'b1;
    cyc("redirect_wins", redir);
    clr(); ihit = 1'b0;
    cyc("istall", istall);
    ex_redirect = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; mem_dreq = 1'b1;
    cyc("dstall_beats_redirect", frozen);
    clr(); ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd8; id_rt = 5'd7;
    cyc("load_nomatch", run_go);

    clr(); wb_halt = 1'b1; mem_dreq = 1'b1;
    cyc("halt_in_wb", frozen);
    clr();
    for (int i = 0; i < 4; i++) cyc("dflush_wait", dfl);
    dflush_done = 1'b1;
    cyc("dflush_done", dfl);
    dflush_done = 1'b0;
    cyc("halted", hlt);
    wb_halt = 1'b1;
    cyc("halted_sticky_a", hlt);
    wb_halt = 1'b0;
    cyc("halted_sticky_b", hlt);

    nRST = 1'b0;
    cyc("async_reset", boot_o);
    nRST = 1'b1;
    cyc("reboot", boot_o);
    cyc("rerun", run_go);

    @(negedge CLK); #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
